// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MIPS MEM stage: fixed-latency word
// access with memStall. Optional macro MEM_ALIGN_CHECK_EN flags address[1:0]!=0.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, stateNext;
  logic [3:0]    cnt, cntNext;
  logic [AW-1:0] idxLat, reqIdx, ldIdx;
  logic [31:0]   dataLat;
  logic          wrLat, misLat, reqMis, ldWr, ldMis;
  logic          req, accept, enterDone;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req    = memRead | memWrite;
  assign reqIdx = address[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign reqMis     = (address[1:0] != 2'b00);
  assign misaligned = (state == DONE) & misLat;
  wire unusedAddr = &{1'b0, address[31:AW+2]};
`else
  assign reqMis     = 1'b0;
  assign misaligned = 1'b0;
  wire unusedAddr = &{1'b0, address[31:AW+2], address[1:0], misLat};
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    memStall  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: if (req) begin
        memStall = 1'b1;
        accept   = 1'b1;
        if (LATENCY == 1) stateNext = DONE;
        else begin
          stateNext = WAIT;
          cntNext   = CNT_INIT;
        end
      end
      WAIT: begin
        memStall = 1'b1;
        if (cnt != 4'd0) cntNext = cnt - 4'd1;
        else             stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Reset wins: nothing is accepted in a reset cycle, so no stall either.
    if (rst) memStall = 1'b0;
  end

  // A LATENCY==1 access enters DONE straight from IDLE, before the latches hold it.
  assign enterDone = (stateNext == DONE) && (state != DONE);
  assign ldIdx     = (state == IDLE) ? reqIdx   : idxLat;
  assign ldWr      = (state == IDLE) ? memWrite : wrLat;
  assign ldMis     = (state == IDLE) ? reqMis   : misLat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      readData <= '0;
      idxLat   <= '0;
      dataLat  <= '0;
      wrLat    <= 1'b0;
      misLat   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        idxLat  <= reqIdx;
        dataLat <= writeData;
        wrLat   <= memWrite;
        misLat  <= reqMis;
      end
      if (enterDone && !ldWr) readData <= ldMis ? '0 : mem[ldIdx];
      if (state == DONE && wrLat && !misLat) mem[idxLat] <= dataLat;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded random + directed bench for data_mem_responder; the reference
// model is a plain word array updated at issue time.
module tb_data_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst, memRead, memWrite;
  logic [31:0] address, writeData, readData;
  logic        memStall, misaligned;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .memStall(memStall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rd; logic mis; } exp_t;
  exp_t        q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] mdlRd;
  int          total = 0, bad = 0;
  bit          inDone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a DONE cycle is the first non-stall cycle after a stall run.
  logic [31:0] heldRd = '0;
  bit          prevStall = 0;
  int          stallRun = 0;
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 0; stallRun = 0; heldRd = '0;
    end else if (memStall) begin
      stallRun++; prevStall = 1;
      chk("stall_misaligned", {31'b0, misaligned}, 32'd0);
      chk("stall_readData_held", readData, heldRd);
    end else if (prevStall) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_readData", readData, e.rd);
        chk("done_misaligned", {31'b0, misaligned}, {31'b0, e.mis});
        chk("stall_cycles", stallRun, LATENCY);
        heldRd = e.rd;
      end
      prevStall = 0; stallRun = 0;
    end else begin
      chk("idle_misaligned", {31'b0, misaligned}, 32'd0);
      chk("idle_readData_held", readData, heldRd);
    end
  end

  task automatic doReset(input int cycles);
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mdlRd = '0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0; inDone = 0;
  endtask

  task automatic idle(input int n);
    memRead = 1'b0; memWrite = 1'b0;
    repeat (n) begin
      @(negedge clk); chk("idle_memStall", {31'b0, memStall}, 32'd0);
      @(posedge clk); #1;
    end
    if (n > 0) inDone = 0;
  endtask

  // Issue one access and return inside its DONE cycle, inputs still held.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    bit   mis;
    memRead = rd; memWrite = wr; address = a; writeData = d;
    idx = int'((a / 4) % DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a % 4) != 0;
`else
    mis = 0;
`endif
    if (wr) begin
      if (!mis) mdl[idx] = d;
    end else mdlRd = mis ? 32'd0 : mdl[idx];
    e.rd = mdlRd; e.mis = mis;
    q.push_back(e);
    if (inDone) begin @(posedge clk); #1; end
    repeat (LATENCY) begin @(posedge clk); #1; end
    inDone = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    address = '0; writeData = '0; inDone = 0;
    doReset(2);
    idle(10);
    chk("reset_readData", readData, 32'd0);

    access(0, 1, 32'h10, 32'hDEADBEEF); idle(1);
    access(1, 0, 32'h10, 32'h0);        idle(3);

    access(0, 1, 32'h0, 32'h1);
    access(0, 1, 32'h4, 32'h2);
    access(1, 0, 32'h0, 32'h0);
    access(1, 0, 32'h4, 32'h0);         idle(1);

    access(0, 1, 32'h400, 32'hA5A5A5A5);
    access(1, 0, 32'h0, 32'h0);
    access(1, 1, 32'h8, 32'h77);
    access(1, 0, 32'h8, 32'h0);         idle(1);

    // Reset while a store sits in WAIT: it must be discarded.
    memRead = 1'b0; memWrite = 1'b1; address = 32'h20; writeData = 32'h55;
    @(posedge clk); #1;
    doReset(1);
    @(negedge clk); chk("post_reset_memStall", {31'b0, memStall}, 32'd0);
    @(posedge clk); #1;
    access(1, 0, 32'h20, 32'h0);        idle(1);

    access(0, 1, 32'h22, 32'h99);       idle(1);
    access(1, 0, 32'h20, 32'h0);        idle(1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      bit          rd, wr;
      a  = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) << 10);
      if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      if (!rd && !wr) rd = 1;
      access(rd, wr, a, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
